reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port (en/D) of one N-bit
//  register among NREQ requesters in the SIMD AES datapath.
//  Requesters post data with a level req; the arbiter picks one winner per
//  cycle and drives the register write port with registered outputs.
//  It returns a one-cycle ack to the winner and reports the winner's index.
//  Sits between the lane/round-control units and the shared state/key register.
// PARAMETERS
//  N     32             data width of the shared register
//  NREQ  4              number of requesters (>=2)
//  IDW   $clog2(NREQ)   width of grant_id
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        asynchronous, active-low reset
//  req       in   NREQ     request level; bit i = requester i
//  data      in   NREQ*N   packed write data; requester i at [i*N +: N]
//  lock      in   NREQ     burst lock; present only with REG_ARB_LOCK_EN
//  ack       out  NREQ     one-hot, one-cycle pulse to the served requester
//  reg_en    out  1        write enable to the shared register
//  reg_d     out  N        write data to the shared register
//  grant_id  out  IDW      index of the requester served this cycle
// BEHAVIOUR
//  - Reset (rst=0): ack=0, reg_en=0, reg_d=0, grant_id=0, rr pointer ptr=0.
//    All clear immediately, independent of clk.
//  - Eligible set per cycle: elig = req & ~ack. The requester being acked
//    this cycle is masked, so one held req is never served twice.
//  - Arbitration is combinational on elig. The winner is the first set bit
//    searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (wraps modulo NREQ).
//  - On the clk edge when elig != 0:
//      reg_en <= 1, reg_d <= data[win], grant_id <= win, ack <= onehot(win)
//      ptr <= (win == NREQ-1) ? 0 : win+1
//  - On the clk edge when elig == 0: reg_en <= 0, ack <= 0.
//    reg_d, grant_id and ptr hold their values.
//  - Latency: req seen at edge k gives reg_en/ack high in cycle k+1.
//    The register captures reg_d at edge k+1.
//  - Requester contract: hold req and data stable until ack is seen high.
//    Drop req, or present new data, in the cycle after ack.
//  - Throughput: 1 write per cycle when requests alternate between
//    requesters. A single requester holding req is served every 2nd cycle.
//  - Exactly one ack bit is high whenever reg_en=1. ack=0 whenever reg_en=0.
//  - Deasserting req before ack withdraws the request with no side effect.
//  - Reset mid-operation: an in-flight write is dropped, since reg_en goes
//    low asynchronously. After release, arbitration restarts with ptr=0, and
//    held requests are re-served.
// CONFIGURATION
//  REG_ARB_LOCK_EN defined:
//    - Adds the lock input.
//    - If the last winner w has ack[w]=1, req[w]=1 and lock[w]=1, w is
//      re-granted at the next edge. This bypasses the ack mask and leaves ptr
//      at its current value, giving back-to-back writes every cycle.
//    - The lock ends when lock[w] or req[w] falls. Normal round robin then
//      resumes from ptr.
//  REG_ARB_LOCK_EN undefined:
//    - There is no lock port; the block is pure round robin.
// TESTING
//  1 rst=0 with req=4'b1111 -> ack=0, reg_en=0, reg_d=0, grant_id=0 at once.
//    After release, the first grant goes to id 0.
//  2 req=4'b0100, data2=32'h11111 for one request ->
//    next cycle: reg_en=1, reg_d=32'h11111, grant_id=2, ack=4'b0100.
//    Then reg_en=0.
//  3 req=4'b1111 held, each requester reloads data after its ack ->
//    grant_id sequence 0,1,2,3,0,1 with reg_en=1 every cycle.
//  4 req=4'b0001 held continuously, data0=32'hAAAAA ->
//    reg_en pattern 1,0,1,0 and ack[0] pulses every second cycle.
//  5 rst=0 mid-way through scenario 3, while grant_id=2 ->
//    outputs clear immediately. After release the sequence restarts 0,1,2,3.
//  6 (REG_ARB_LOCK_EN) req=4'b0011, lock=4'b0010 from reset -> grants 0,1,1,1.
//    Clear lock[1] -> the next grant is 0, then 1, alternating.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the write port of one shared register
//
// Purpose: NREQ requesters post write data with a level request. One winner
// per cycle is chosen round-robin and drives the shared register's en/D port
// through registered outputs. The winner receives a one-cycle ack and its
// index is reported on grant_id_o.
//
// Optional feature macro: REG_ARB_LOCK_EN (adds lock_i burst lock).
//
// Ports:
//   clk_i       in   1        clock, rising edge
//   rst_ni      in   1        asynchronous active-low reset
//   req_i       in   NREQ     request level, bit i = requester i
//   data_i      in   NREQ*N   packed write data, requester i at [i*N +: N]
//   lock_i      in   NREQ     burst lock (REG_ARB_LOCK_EN only)
//   ack_o       out  NREQ     one-hot one-cycle pulse to the served requester
//   reg_en_o    out  1        write enable to the shared register
//   reg_d_o     out  N        write data to the shared register
//   grant_id_o  out  IDW      index of the requester served this cycle

module reg_write_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*N-1:0] data_i,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock_i,
`endif
    output logic [NREQ-1:0]   ack_o,
    output logic              reg_en_o,
    output logic [N-1:0]      reg_d_o,
    output logic [IDW-1:0]    grant_id_o
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [NREQ-1:0] ack_q, ack_d;
    logic            en_q, en_d;
    logic [N-1:0]    d_q, d_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic [NREQ-1:0] elig;
    logic [IDW-1:0]  win;
    logic            hold;

    // First eligible index searching from p upwards with wrap. Scanning from
    // the farthest candidate to the nearest lets the nearest one win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] e,
                                               input logic [IDW-1:0]  p);
        logic [IDW:0]   s;
        logic [IDW-1:0] idx;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = {1'b0, p} + (IDW+1)'(k);
            if (s >= NREQ_W) begin
                s = s - NREQ_W;
            end
            idx = s[IDW-1:0];
            if (e[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    always_comb begin
        // The requester acked this cycle is masked so a held req that has
        // just been served is not served again on the next edge.
        elig = req_i & ~ack_q;
        win  = rr_pick(elig, ptr_q);

`ifdef REG_ARB_LOCK_EN
        // Burst lock: the last winner keeps the port while it holds both req
        // and lock; ack mask and pointer advance are bypassed.
        hold = en_q & req_i[gid_q] & lock_i[gid_q];
`else
        hold = 1'b0;
`endif

        ack_d = '0;
        en_d  = 1'b0;
        d_d   = d_q;
        gid_d = gid_q;
        ptr_d = ptr_q;

        if (hold) begin
            en_d         = 1'b1;
            ack_d[gid_q] = 1'b1;
            d_d          = data_i[gid_q*N +: N];
        end else if (|elig) begin
            en_d       = 1'b1;
            ack_d[win] = 1'b1;
            d_d        = data_i[win*N +: N];
            gid_d      = win;
            ptr_d      = (win == LAST_ID) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= '0;
            en_q  <= 1'b0;
            d_q   <= '0;
            gid_q <= '0;
            ptr_q <= '0;
        end else begin
            ack_q <= ack_d;
            en_q  <= en_d;
            d_q   <= d_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
        end
    end

    assign ack_o      = ack_q;
    assign reg_en_o   = en_q;
    assign reg_d_o    = d_q;
    assign grant_id_o = gid_q;

endmodule
